// File: rtl/uc_eng_collector.sv
// uc_eng_collector: per-engine unit-literal FIFOs with round-robin hand-off to uc_arbiter.
// Define UC_COL_DEDUP_EN to discard a candidate equal to the last emitted literal.
module uc_eng_collector #(
   parameter int NUM_ENG = 4,
   parameter int LIT_W   = 8,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_ENG-1:0]       eng_push,
   input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
   output logic [NUM_ENG-1:0]       eng_full,
   input  logic [NUM_ENG-1:0]       engmask,
   input  logic                     flush,
   input  logic                     eng2uca_rd,
   output logic                     eng2uca_valid,
   output logic                     eng2uca_empty,
   output logic [LIT_W-1:0]         eng2uca,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int RW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   // Handshake: eng2uca is meaningful while eng2uca_valid is high; the arbiter takes it by
   // raising eng2uca_rd, and the next literal (or valid low) appears after that clock edge.

   logic [LIT_W-1:0]   mem_q [NUM_ENG][DEPTH];
   logic [PW-1:0]      wr_ptr_q [NUM_ENG];
   logic [PW-1:0]      wr_ptr_d [NUM_ENG];
   logic [PW-1:0]      rd_ptr_q [NUM_ENG];
   logic [PW-1:0]      rd_ptr_d [NUM_ENG];
   logic [RW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               valid_q, valid_d;
   logic [LIT_W-1:0]   out_q, out_d;
   logic               ovf_q, ovf_d;
   logic [NUM_ENG-1:0] empty, full, deq, wr_en;
   logic [RW-1:0]      idx [NUM_ENG];
   logic               load_en, found;
   logic [RW-1:0]      sel;
   logic [LIT_W-1:0]   cand;
`ifdef UC_COL_DEDUP_EN
   logic [LIT_W-1:0]   last_q, last_d;
`endif

   always_comb begin
      for (int i = 0; i < NUM_ENG; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                    (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      end
   end

   // Scan engines starting at rr_ptr; the first eligible, non-empty one wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_ENG; k++) begin
         idx[k] = RW'((int'(rr_ptr_q) + k) % NUM_ENG);
         if (!found && engmask[idx[k]] && !empty[idx[k]]) begin
            found = 1'b1;
            sel   = idx[k];
         end
      end
      cand = mem_q[sel][rd_ptr_q[sel][AW-1:0]];
   end

   always_comb begin
      load_en  = !valid_q || eng2uca_rd;
      deq      = '0;
      valid_d  = valid_q;
      out_d    = out_q;
      rr_ptr_d = rr_ptr_q;
      ovf_d    = ovf_q;
`ifdef UC_COL_DEDUP_EN
      last_d   = last_q;
`endif
      if (load_en) begin
         valid_d = 1'b0;
         if (found) begin
            deq[sel] = 1'b1;
            rr_ptr_d = (sel == RW'(NUM_ENG - 1)) ? '0 : sel + RW'(1);
`ifdef UC_COL_DEDUP_EN
            if (cand != last_q) begin
               valid_d = 1'b1;
               out_d   = cand;
               last_d  = cand;
            end
`else
            valid_d = 1'b1;
            out_d   = cand;
`endif
         end
      end
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      for (int i = 0; i < NUM_ENG; i++) begin
         wr_en[i] = eng_push[i] && (eng_lit[i*LIT_W +: LIT_W] != '0) && (!full[i] || deq[i]);
         if (eng_push[i] && (eng_lit[i*LIT_W +: LIT_W] != '0) && full[i] && !deq[i])
            ovf_d = 1'b1;
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(wr_en[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(deq[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < NUM_ENG; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         valid_q <= 1'b0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
`ifdef UC_COL_DEDUP_EN
         last_q  <= '0;
`endif
         if (rst)
            rr_ptr_q <= '0;
      end else begin
         for (int i = 0; i < NUM_ENG; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         valid_q  <= valid_d;
         out_q    <= out_d;
         ovf_q    <= ovf_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef UC_COL_DEDUP_EN
         last_q   <= last_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENG; i++) begin
         if (wr_en[i] && !rst && !flush)
            mem_q[i][wr_ptr_q[i][AW-1:0]] <= eng_lit[i*LIT_W +: LIT_W];
      end
   end

   assign eng_full      = full;
   assign eng2uca_valid = valid_q;
   assign eng2uca       = out_q;
   assign overflow      = ovf_q;
   assign eng2uca_empty = !valid_q && ~|(engmask & ~empty);

endmodule
